// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter feeding a single 8N1 UART transmitter.
// Each accepted request latches one byte and sends start, 8 data bits LSB first, stop.
module uart_tx_scheduler #(
   parameter int NUM_REQ      = 4,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [8*NUM_REQ-1:0]       data,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [$clog2(NUM_REQ)-1:0] cur_id,
   output logic                       busy,
   output logic                       tx_done,
   output logic                       utxd
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam int BW  = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t               state_q, state_d;
   logic [BW-1:0]        baud_q, baud_d;
   logic [2:0]           bit_q, bit_d;
   logic [7:0]           shift_q, shift_d;
   logic [IDW-1:0]       cur_id_q, cur_id_d;
   logic [IDW-1:0]       last_q, last_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic                 done_q, done_d;
   logic                 utxd_q, utxd_d;

   logic [7:0]           req_byte [NUM_REQ];
   logic                 found;
   logic [IDW-1:0]       winner;
   int                   idx;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
         assign req_byte[gi] = data[8*gi +: 8];
      end
   endgenerate

   // Round-robin search starting just after the most recent grant.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last_q) + k) % NUM_REQ;
         if (!found && req[IDW'(idx)]) begin
            found  = 1'b1;
            winner = IDW'(idx);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      cur_id_d = cur_id_q;
      last_d   = last_q;
      utxd_d   = utxd_q;
      gnt_d    = '0;
      case (state_q)
         IDLE: begin
            utxd_d = 1'b1;
            baud_d = '0;
            bit_d  = '0;
            if (found) begin
               state_d        = START;
               shift_d        = req_byte[winner];
               cur_id_d       = winner;
               last_d         = winner;
               gnt_d[winner]  = 1'b1;
               utxd_d         = 1'b0;
            end
         end
         START: begin
            if (baud_q == BAUD_LAST) begin
               baud_d  = '0;
               state_d = DATA;
               utxd_d  = shift_q[0];
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         DATA: begin
            if (baud_q == BAUD_LAST) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  bit_d   = '0;
                  state_d = STOP;
                  utxd_d  = 1'b1;
               end else begin
                  // Shift so the next bit to send is always at position 1.
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
                  utxd_d  = shift_q[1];
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         STOP: begin
            utxd_d = 1'b1;
            if (baud_q == BAUD_LAST) begin
               baud_d  = '0;
               state_d = IDLE;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      done_d = (state_d == STOP) && (baud_d == BAUD_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         cur_id_q <= '0;
         last_q   <= IDW'(NUM_REQ - 1);
         gnt_q    <= '0;
         done_q   <= 1'b0;
         utxd_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         cur_id_q <= cur_id_d;
         last_q   <= last_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
         utxd_q   <= utxd_d;
      end
   end

   assign gnt     = gnt_q;
   assign cur_id  = cur_id_q;
   assign busy    = (state_q != IDLE);
   assign tx_done = done_q;
   assign utxd    = utxd_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler (4 requesters, 4 clocks per bit).
// Each cycle compares the vector {gnt, busy, tx_done, utxd, cur_id}.
module tb_uart_tx_scheduler;

   localparam int N   = 4;
   localparam int CPB = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  req = '0;
   logic [8*N-1:0] data = '0;
   logic [N-1:0]  gnt;
   logic [1:0]    cur_id;
   logic          busy;
   logic          tx_done;
   logic          utxd;

   int checks   = 0;
   int failures = 0;

   uart_tx_scheduler #(.NUM_REQ(N), .CLKS_PER_BIT(CPB)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .data    (data),
      .gnt     (gnt),
      .cur_id  (cur_id),
      .busy    (busy),
      .tx_done (tx_done),
      .utxd    (utxd)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [8:0] obsv();
      return {gnt, busy, tx_done, utxd, cur_id};
   endfunction

   task automatic chk(input string tag, input logic [8:0] o, input logic [8:0] e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, o, e);
      end
   endtask

   // Idle check ignores cur_id, which only has meaning during a frame.
   task automatic chk_idle(input string tag);
      logic [8:0] o;
      o = obsv();
      o[1:0] = 2'b00;
      chk(tag, o, 9'b0000_0_0_1_00);
   endtask

   // Called in the first START cycle; checks all 40 frame cycles and the gap cycle.
   task automatic frame_check(input logic [7:0] b, input logic [1:0] id, input int hook_c,
                              input logic [3:0] hook_req, input logic [7:0] hook_d3);
      logic [9:0] bits;
      logic [3:0] oh;
      logic [8:0] e;
      bits   = {1'b1, b, 1'b0};
      oh     = 4'b0000;
      oh[id] = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (c > 0) tick();
         e = {(c == 0) ? oh : 4'b0000, 1'b1, (c == 39), bits[c/CPB], id};
         chk($sformatf("frame id%0d c%0d", id, c), obsv(), e);
         if (c == hook_c) begin
            req          = hook_req;
            data[31:24]  = hook_d3;
         end
      end
      tick();
      chk_idle($sformatf("gap after id%0d", id));
   endtask

   initial begin
      logic [3:0] ids [4];
      data = {8'h3C, 8'hC3, 8'hA5, 8'h5A};

      // Reset state
      rst = 1'b1;
      tick();
      tick();
      chk("reset", obsv(), 9'b0000_0_0_1_00);
      rst = 1'b0;
      tick();
      chk_idle("idle no req");

      // Single frame of 0xA5 from requester 1
      req = 4'b0010;
      tick();
      frame_check(8'hA5, 2'd1, 0, 4'b0000, data[31:24]);

      // All four requesting from reset release: order 0,1,2,3, one idle cycle apart
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      req = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         logic [3:0] drop;
         drop    = req;
         drop[i] = 1'b0;
         tick();
         frame_check(data[8*i +: 8], 2'(i), 0, drop, data[31:24]);
      end

      // req0 and req2 held: grants alternate 0,2,0,2
      ids = '{4'd0, 4'd2, 4'd0, 4'd2};
      req = 4'b0101;
      for (int i = 0; i < 4; i++) begin
         tick();
         frame_check(data[8*ids[i] +: 8], ids[i][1:0], -1, 4'b0000, data[31:24]);
      end
      req = 4'b0000;

      // Reset during the third data bit aborts the frame
      req = 4'b0001;
      tick();
      chk("abort grant", obsv(), 9'b0001_1_0_0_00);
      req = 4'b0101;
      for (int c = 1; c <= 13; c++) tick();
      chk("abort bit2", obsv(), 9'b0000_1_0_0_00);
      rst = 1'b1;
      tick();
      chk("abort reset1", obsv(), 9'b0000_0_0_1_00);
      tick();
      chk("abort reset2 no grant", obsv(), 9'b0000_0_0_1_00);
      rst = 1'b0;
      tick();
      frame_check(8'h5A, 2'd0, 0, 4'b0100, data[31:24]);
      tick();
      frame_check(8'hC3, 2'd2, 0, 4'b0000, data[31:24]);

      // data3 corrupted one cycle after the grant: frame still carries 0x3C
      req = 4'b1000;
      tick();
      frame_check(8'h3C, 2'd3, 1, 4'b0000, 8'hFF);

      // req1 raised during requester 0's stop bit is served after the gap
      req = 4'b0001;
      tick();
      frame_check(8'h5A, 2'd0, 37, 4'b0010, data[31:24]);
      tick();
      frame_check(8'hA5, 2'd1, 0, 4'b0000, data[31:24]);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_idle($sformatf("tail idle %0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, the number of requesters (2..8).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, the clk cycles per UART bit (>=2).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset; it is synchronous and active-high.
REQ-005 SHALL have port req, input, NUM_REQ, per-requester transmit request, level.
REQ-006 SHALL have port data, input, 8*NUM_REQ, the byte of requester i on data[8i+7:8i].
REQ-007 SHALL have port gnt, output, NUM_REQ, a one-hot one-cycle accept pulse.
REQ-008 SHALL have port cur_id, output, clog2(NUM_REQ), the index of the requester owning the current frame.
REQ-009 SHALL have port busy, output, 1, high while a frame is in progress.
REQ-010 SHALL have port tx_done, output, 1, a one-cycle pulse in the last cycle of the stop bit.
REQ-011 SHALL have port utxd, output, 1, the serial line to the UART receiver; it idles high.

Function
REQ-012 SHALL implement the FSM states IDLE, START, DATA and STOP.
REQ-013 IDLE: when any req bit is high, on that edge SHALL latch the winner's byte, set cur_id, go to START and register gnt[winner]=1 for exactly one cycle (the first START cycle).
REQ-014 Winner SHALL be chosen round-robin: search starts at index (last_grant+1) mod NUM_REQ; last_grant updates only on a grant.
REQ-015 START SHALL drive utxd=0 for CLKS_PER_BIT cycles.
REQ-016 DATA SHALL drive the 8 latched bits LSB first, each for CLKS_PER_BIT cycles.
REQ-017 STOP SHALL drive utxd=1 for CLKS_PER_BIT cycles; tx_done SHALL be 1 in its final cycle; the next state is IDLE.
REQ-018 A frame SHALL last exactly 10*CLKS_PER_BIT cycles from the first START cycle.
REQ-019 The minimum gap between back-to-back frames SHALL be exactly 1 IDLE cycle, with utxd=1.
REQ-020 Requesters hold req and data stable until gnt is seen; changes to data after the grant edge SHALL NOT affect the frame in flight.
REQ-021 req changes while not in IDLE SHALL be ignored; no request is queued internally.
REQ-022 utxd SHALL be driven from a flop (glitch-free).
REQ-023 The bit counter (0..7) and baud counter (0..CLKS_PER_BIT-1) SHALL wrap to 0 on state exit.
REQ-024 busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE.
REQ-025 gnt and tx_done SHALL never be high in the same cycle.

Reset
REQ-026 When rst=1 at an edge, next cycle: state=IDLE, utxd=1, busy=0, gnt=0, tx_done=0, cur_id=0, counters=0, last_grant=NUM_REQ-1 (requester 0 has first priority).
REQ-027 Reset mid-frame SHALL abort the frame immediately, with no stop bit and no tx_done pulse.
REQ-028 No grant SHALL be issued in any cycle in which rst=1.

Verification (NUM_REQ=4, CLKS_PER_BIT=4)
REQ-029 req=0010, data1=0xA5 -> gnt=0010 for 1 cycle; utxd sequence 0,1,0,1,0,0,1,0,1,1, each held 4 clks; tx_done at clk 40; busy=1 for 40 clks.
REQ-030 req=1111 held from reset release, each requester dropping req after its gnt -> grant order 0,1,2,3; each frame followed by exactly 1 idle cycle.
REQ-031 req0 and req2 held high continuously -> grants alternate 0,2,0,2; requesters 1 and 3 never granted.
REQ-032 rst asserted in the 3rd DATA bit -> next cycle utxd=1, busy=0, no tx_done; after release, with req=0101, requester 0 is granted first.
REQ-033 data3 changed from 0x3C to 0xFF one cycle after gnt[3] -> transmitted bits match 0x3C.
REQ-034 req1 raised during requester 0's STOP -> req1 ignored until IDLE, then granted in the IDLE cycle; no requests lost or duplicated.
